iterative_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider for the execute stage; implements ARMv8 UDIV and SDIV.
- It is the subtract-direction counterpart to the datapath's combinational adders: it iteratively subtracts instead of adding.
- It sits beside the ALU. The pipeline stalls while busy is high and captures quotient when done pulses.

---
 rtl/iterative_divider.sv | 143 ++++++++++++++
 tb/tb_iterative_divider.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for UDIV/SDIV: one quotient bit per clock.
// Operands are reduced to magnitudes up front, and the sign is restored when the result is written.
module iterative_divider #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e r_state;
    state_e w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_done;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_is_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_dvd_neg  = i_is_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg  = i_is_signed & i_divisor[WIDTH-1];
    assign w_dvs_zero = (i_divisor == '0);
    assign w_dvd_abs  = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_abs  = w_dvs_neg ? -i_divisor : i_divisor;
    assign w_is_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // The shifted remainder can carry into bit WIDTH, and in that case it always exceeds the divisor.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_ge       = w_shift[WIDTH] | ~w_trial[WIDTH];
    assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = w_dvs_zero ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (w_is_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy        = (r_state != StIdle);
        o_done        = r_done;
        o_quotient    = r_quotient;
        o_remainder   = r_remainder;
        o_div_by_zero = r_div_by_zero;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt         <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_dvs         <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // done trails the DONE state by one edge, so results are already stable when it pulses.
            r_done <= (r_state == StDone);
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (w_dvs_zero) begin
                            r_quotient    <= '0;
                            r_remainder   <= i_dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_q      <= w_dvd_abs;
                            r_dvs    <= w_dvs_abs;
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                            r_sign_r <= w_dvd_neg;
                        end
                    end
                end
                StCalc: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_is_last) begin
                        r_quotient    <= r_sign_q ? -w_q_next : w_q_next;
                        r_remainder   <= r_sign_r ? -w_rem_next : w_rem_next;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider against a plain-arithmetic reference model.
module tb_iterative_divider;

    localparam int unsigned WIDTH = 64;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int pulse_cnt = 0;

    iterative_divider #(
        .WIDTH(WIDTH),
        .CNT_W(7)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_start      (start),
        .i_is_signed  (is_signed),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_busy       (busy),
        .o_done       (done),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: ARMv8 UDIV/SDIV semantics with truncation toward zero.
    function automatic void model(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output int lat);
        longint sa;
        longint sb;
        if (b == 64'd0) begin
            q = 64'd0; r = a; dz = 1'b1; lat = 1;
        end else begin
            dz = 1'b0;
            lat = WIDTH + 1;
            if (!sgn) begin
                q = a / b;
                r = a % b;
            end else if (a == MIN_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = MIN_NEG;
                r = 64'd0;
            end else begin
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
            end
        end
    endfunction

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic sgn, input logic [63:0] a, input logic [63:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        lat = cyc - e0;
        if (!seen) chk({tag, " done timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic sgn, input logic [63:0] a,
                                input logic [63:0] b, input int lat);
        logic [63:0] eq;
        logic [63:0] er;
        logic        edz;
        int          elat;
        model(sgn, a, b, eq, er, edz, elat);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edz});
        chk({tag, " busy in done cycle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [63:0] a,
                          input logic [63:0] b);
        int lat;
        issue(sgn, a, b);
        @(negedge clk);
        chk({tag, " busy after accept"}, {63'd0, busy}, 64'd1);
        chk({tag, " done early"}, {63'd0, done}, 64'd0);
        wait_done(tag, lat);
        check_result(tag, sgn, a, b, lat);
        @(negedge clk);
        chk({tag, " done single pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int lat;
        int cnt;
        int p0;
        logic        sgn;
        logic [63:0] a;
        logic [63:0] b;

        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", remainder, 64'd0);
        chk("reset div_by_zero", {63'd0, div_by_zero}, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("udiv 100/7", 1'b0, 64'd100, 64'd7);
        chk("udiv 100/7 literal q", quotient, 64'd14);
        run_op("sdiv -100/7", 1'b1, -64'sd100, 64'd7);
        chk("sdiv -100/7 literal r", remainder, -64'sd2);
        run_op("sdiv 100/-7", 1'b1, 64'd100, -64'sd7);
        chk("sdiv 100/-7 literal q", quotient, -64'sd14);
        run_op("div by zero", 1'b0, 64'h1234, 64'd0);
        chk("div by zero literal r", remainder, 64'h1234);
        run_op("sdiv overflow", 1'b1, MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("udiv extreme", 1'b0, MIN_NEG, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sdiv zero div", 1'b1, -64'sd5, 64'd0);

        // A second start during CALC must be dropped.
        issue(1'b0, 64'd12345, 64'd11);
        repeat (10) @(negedge clk);
        dividend = 64'd999;
        divisor  = 64'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start while busy", lat);
        check_result("start while busy", 1'b0, 64'd12345, 64'd11, lat);
        @(negedge clk);

        // Reset mid-operation clears outputs and suppresses done.
        issue(1'b0, 64'd5000, 64'd3);
        repeat (30) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort quotient", quotient, 64'd0);
        chk("abort remainder", remainder, 64'd0);
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        chk("abort no done pulse", 64'(cnt), 64'd0);
        run_op("after abort", 1'b0, 64'd5000, 64'd3);

        // Back-to-back: second start in the done cycle.
        p0 = pulse_cnt;
        issue(1'b0, 64'd1000, 64'd10);
        wait_done("b2b first", lat);
        check_result("b2b first", 1'b0, 64'd1000, 64'd10, lat);
        issue(1'b0, 64'd7, 64'd3);
        @(negedge clk);
        chk("b2b second busy", {63'd0, busy}, 64'd1);
        wait_done("b2b second", lat);
        check_result("b2b second", 1'b0, 64'd7, 64'd3, lat);
        @(negedge clk);
        chk("b2b done low after", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        chk("b2b pulse count", 64'(pulse_cnt - p0), 64'd2);
        @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            int sel;
            sgn = 1'($urandom_range(0, 1));
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 100000));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) b = 64'd0;
            else if (sel < 4) b = 64'($urandom_range(1, 1000));
            else b = {$urandom(), $urandom()};
            if (sgn && sel != 0 && $urandom_range(0, 1) == 1) b = -b;
            run_op($sformatf("random %0d", n), sgn, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
